// File: rtl/mix_inlet_sequencer.sv
// Three-inlet dosing sequencer: settle each nonzero inlet, pump its dose, then drain. Outputs are registered and change one cycle after the deciding input.
// Define MIX_FLUSH_EN to add a flush pass (flush valve plus FLUSH_STEPS pulses and a trailing outlet hold) after the drain.
module mix_inlet_sequencer #(
    parameter int CNT_W       = 16,
    parameter int SETTLE      = 4,
    parameter int STEP_DIV    = 2,
    parameter int OUTLET_HOLD = 8,
    parameter int FLUSH_STEPS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] dose1,
    input  logic [CNT_W-1:0] dose2,
    input  logic [CNT_W-1:0] dose3,
    output logic             busy,
    output logic             done,
    output logic             valve_soln1,
    output logic             valve_soln2,
    output logic             valve_soln3,
    output logic             valve_out,
    output logic             valve_flush,
    output logic             pump_step
);

    localparam int TW = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_PUMP,
        S_DRAIN,
        S_DONE
`ifdef MIX_FLUSH_EN
        , S_FLUSH
`endif
    } state_t;

    state_t            state, nxt_state;
    logic [1:0]        sel, nxt_sel;
    logic [TW-1:0]     tmr, nxt_tmr;
    logic [CNT_W-1:0]  cnt, nxt_cnt;
    logic [CNT_W-1:0]  d1q, d2q, d3q;
    logic [CNT_W-1:0]  cur_dose;
    logic [1:0]        next_sel;
    logic              has_next;
    logic              last_pulse;
    logic              div_wrap;
    logic              nxt_busy, nxt_done, nxt_v1, nxt_v2, nxt_v3, nxt_vout, nxt_pump;
`ifdef MIX_FLUSH_EN
    logic              flushed, nxt_flushed;
    logic              nxt_vflush;
`endif

    // sel==3 marks the flush pass; it never occurs in the default build.
    always_comb begin
        case (sel)
            2'd0:    cur_dose = d1q;
            2'd1:    cur_dose = d2q;
            2'd2:    cur_dose = d3q;
            default: cur_dose = CNT_W'(FLUSH_STEPS);
        endcase
    end

    always_comb begin
        has_next = 1'b1;
        next_sel = 2'd2;
        if (sel == 2'd0 && d2q != '0)
            next_sel = 2'd1;
        else if (sel != 2'd2 && d3q != '0)
            next_sel = 2'd2;
        else
            has_next = 1'b0;
    end

    // cnt holds the number of the pulse issued in the current tmr==0 cycle.
    assign last_pulse = (tmr == '0) && (cnt == cur_dose);
    assign div_wrap   = (tmr == TW'(STEP_DIV - 1));

    always_comb begin
        nxt_state = state;
        nxt_sel   = sel;
        nxt_tmr   = tmr;
        nxt_cnt   = cnt;
`ifdef MIX_FLUSH_EN
        nxt_flushed = flushed;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    nxt_tmr = '0;
                    nxt_cnt = '0;
`ifdef MIX_FLUSH_EN
                    nxt_flushed = 1'b0;
`endif
                    if (dose1 != '0) begin
                        nxt_state = S_SETTLE;
                        nxt_sel   = 2'd0;
                    end else if (dose2 != '0) begin
                        nxt_state = S_SETTLE;
                        nxt_sel   = 2'd1;
                    end else if (dose3 != '0) begin
                        nxt_state = S_SETTLE;
                        nxt_sel   = 2'd2;
                    end else begin
                        nxt_state = S_DONE;
                    end
                end
            end
            S_SETTLE: begin
                if (tmr == TW'(SETTLE - 1)) begin
                    nxt_state = S_PUMP;
                    nxt_tmr   = '0;
                    nxt_cnt   = CNT_W'(1);
                end else begin
                    nxt_tmr = tmr + TW'(1);
                end
            end
            S_PUMP: begin
                if (last_pulse) begin
                    nxt_tmr = '0;
                    if (has_next) begin
                        nxt_state = S_SETTLE;
                        nxt_sel   = next_sel;
                    end else begin
                        nxt_state = S_DRAIN;
                    end
                end else if (div_wrap) begin
                    nxt_tmr = '0;
                    nxt_cnt = cnt + CNT_W'(1);
                end else begin
                    nxt_tmr = tmr + TW'(1);
                end
            end
`ifdef MIX_FLUSH_EN
            S_FLUSH: begin
                if (last_pulse) begin
                    nxt_tmr     = '0;
                    nxt_state   = S_DRAIN;
                    nxt_flushed = 1'b1;
                end else if (div_wrap) begin
                    nxt_tmr = '0;
                    nxt_cnt = cnt + CNT_W'(1);
                end else begin
                    nxt_tmr = tmr + TW'(1);
                end
            end
`endif
            S_DRAIN: begin
                if (tmr == TW'(OUTLET_HOLD - 1)) begin
                    nxt_tmr = '0;
`ifdef MIX_FLUSH_EN
                    if (!flushed) begin
                        nxt_state = S_FLUSH;
                        nxt_sel   = 2'd3;
                        nxt_cnt   = CNT_W'(1);
                    end else begin
                        nxt_state = S_DONE;
                    end
`else
                    nxt_state = S_DONE;
`endif
                end else begin
                    nxt_tmr = tmr + TW'(1);
                end
            end
            S_DONE:  nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase

        // Abort overrides whatever transition was decided above.
        if (abort && state != S_IDLE) begin
            nxt_state = S_IDLE;
            nxt_tmr   = '0;
            nxt_cnt   = '0;
        end
    end

    // Outputs are decoded from the next state so they can be registered alongside it.
    always_comb begin
        nxt_busy = (nxt_state == S_SETTLE) || (nxt_state == S_PUMP) || (nxt_state == S_DRAIN);
        nxt_vout = (nxt_state == S_PUMP) || (nxt_state == S_DRAIN);
        nxt_pump = (nxt_state == S_PUMP) && (nxt_tmr == '0);
`ifdef MIX_FLUSH_EN
        nxt_vflush = (nxt_state == S_FLUSH);
        nxt_busy   = nxt_busy || nxt_vflush;
        nxt_vout   = nxt_vout || nxt_vflush;
        nxt_pump   = nxt_pump || (nxt_vflush && (nxt_tmr == '0));
`endif
        nxt_done = (nxt_state == S_DONE);
        nxt_v1   = ((nxt_state == S_SETTLE) || (nxt_state == S_PUMP)) && (nxt_sel == 2'd0);
        nxt_v2   = ((nxt_state == S_SETTLE) || (nxt_state == S_PUMP)) && (nxt_sel == 2'd1);
        nxt_v3   = ((nxt_state == S_SETTLE) || (nxt_state == S_PUMP)) && (nxt_sel == 2'd2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            sel         <= '0;
            tmr         <= '0;
            cnt         <= '0;
            d1q         <= '0;
            d2q         <= '0;
            d3q         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            valve_soln1 <= 1'b0;
            valve_soln2 <= 1'b0;
            valve_soln3 <= 1'b0;
            valve_out   <= 1'b0;
            pump_step   <= 1'b0;
        end else begin
            state       <= nxt_state;
            sel         <= nxt_sel;
            tmr         <= nxt_tmr;
            cnt         <= nxt_cnt;
            if (state == S_IDLE && start) begin
                d1q <= dose1;
                d2q <= dose2;
                d3q <= dose3;
            end
            busy        <= nxt_busy;
            done        <= nxt_done;
            valve_soln1 <= nxt_v1;
            valve_soln2 <= nxt_v2;
            valve_soln3 <= nxt_v3;
            valve_out   <= nxt_vout;
            pump_step   <= nxt_pump;
        end
    end

`ifdef MIX_FLUSH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flushed     <= 1'b0;
            valve_flush <= 1'b0;
        end else begin
            flushed     <= nxt_flushed;
            valve_flush <= nxt_vflush;
        end
    end
`else
    assign valve_flush = 1'b0;
`endif

endmodule
